// File: rtl/fault_mem_multi_if.sv
// Access port and fault-table configuration bus of fault_mem_multi.
// FAULT_MEM_HIT_CNT_EN adds the hit_cnt / hit_clr pair.
interface fault_mem_multi_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int IDX_WIDTH  = 2,
  parameter int BIT_WIDTH  = $clog2(DATA_WIDTH)
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  fault_hit;
  logic                  cfg_we;
  logic [IDX_WIDTH-1:0]  cfg_idx;
  logic [2:0]            cfg_type;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic [ADDR_WIDTH-1:0] cfg_aux_addr;
  logic [BIT_WIDTH-1:0]  cfg_bit;
  logic [DATA_WIDTH-1:0] cfg_data;
`ifdef FAULT_MEM_HIT_CNT_EN
  logic [15:0]           hit_cnt;
  logic                  hit_clr;

  modport master (output write_read, address, wdata, cfg_we, cfg_idx, cfg_type,
                         cfg_addr, cfg_aux_addr, cfg_bit, cfg_data, hit_clr,
                  input  rdata, fault_hit, hit_cnt);
  modport slave  (input  write_read, address, wdata, cfg_we, cfg_idx, cfg_type,
                         cfg_addr, cfg_aux_addr, cfg_bit, cfg_data, hit_clr,
                  output rdata, fault_hit, hit_cnt);
`else
  modport master (output write_read, address, wdata, cfg_we, cfg_idx, cfg_type,
                         cfg_addr, cfg_aux_addr, cfg_bit, cfg_data,
                  input  rdata, fault_hit);
  modport slave  (input  write_read, address, wdata, cfg_we, cfg_idx, cfg_type,
                         cfg_addr, cfg_aux_addr, cfg_bit, cfg_data,
                  output rdata, fault_hit);
`endif
endinterface

// File: rtl/fault_mem_multi.sv
// Single-port SRAM model with a programmable table of injected faults, 2-cycle read.
// Optional FAULT_MEM_HIT_CNT_EN adds a saturating fault_hit counter.
module fault_mem_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int CAPACITY   = 511,
  parameter int NUM_FAULTS = 4,
  parameter int IDX_WIDTH  = 2
) (
  input logic              clk,
  input logic              rst_n,
  fault_mem_multi_if.slave bus
);
  localparam int BIT_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);

  typedef enum logic [2:0] {
    F_NONE, F_SA0, F_SA1, F_TF_UP, F_TF_DN, F_STUCK_ADDR, F_CFIN, F_ALIAS
  } fault_e;

  typedef struct packed {
    fault_e                kind;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] aux;
    logic [BIT_WIDTH-1:0]  bit_idx;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                table_q [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] mem [CAPACITY+1];
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_hit;

  logic [ADDR_WIDTH-1:0] eff;
  logic                  alias_hit, stuck_hit, sa_hit, in_range, wr_ok, rd_hit;
  logic [DATA_WIDTH-1:0] stuck_data, old_word, new_word, rd_word;
  logic [NUM_FAULTS-1:0] cfin_fire;
  logic [DATA_WIDTH-1:0] victim_flip [NUM_FAULTS];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eff        = bus.address;
    alias_hit  = 1'b0;
    stuck_hit  = 1'b0;
    stuck_data = '0;
    sa_hit     = 1'b0;
    // Descending scan so the lowest-index match is the one left standing.
    for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
      if (table_q[i].kind == F_ALIAS && table_q[i].addr == bus.address) begin
        eff       = table_q[i].aux;
        alias_hit = 1'b1;
      end
    end
    in_range = (bus.address <= LAST_ADDR) && (eff <= LAST_ADDR);
    old_word = in_range ? mem[eff] : '0;
    for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
      if (table_q[i].kind == F_STUCK_ADDR && table_q[i].addr == eff) begin
        stuck_hit  = 1'b1;
        stuck_data = table_q[i].data;
      end
    end

    new_word = bus.wdata;
    rd_word  = stuck_hit ? stuck_data : old_word;
    // Transition faults judge against the old word; stuck-at forces win afterwards.
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (table_q[i].addr == eff) begin
        if (table_q[i].kind == F_TF_UP && !old_word[table_q[i].bit_idx] && new_word[table_q[i].bit_idx])
          new_word[table_q[i].bit_idx] = 1'b0;
        if (table_q[i].kind == F_TF_DN && old_word[table_q[i].bit_idx] && !new_word[table_q[i].bit_idx])
          new_word[table_q[i].bit_idx] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (table_q[i].addr == eff && (table_q[i].kind == F_SA0 || table_q[i].kind == F_SA1)) begin
        new_word[table_q[i].bit_idx] = (table_q[i].kind == F_SA1);
        rd_word[table_q[i].bit_idx]  = (table_q[i].kind == F_SA1);
        sa_hit = 1'b1;
      end
    end
    if (!in_range) rd_word = '0;
    rd_hit = in_range && (alias_hit || stuck_hit || sa_hit);
    wr_ok  = bus.write_read && in_range && !stuck_hit;

    for (int i = 0; i < NUM_FAULTS; i++) begin
      cfin_fire[i] = wr_ok && table_q[i].kind == F_CFIN && table_q[i].aux == eff &&
                     table_q[i].addr != table_q[i].aux && table_q[i].addr <= LAST_ADDR &&
                     (old_word[table_q[i].bit_idx] != new_word[table_q[i].bit_idx]);
    end
    // Entries sharing a victim merge their flips so none is lost to a later write.
    for (int i = 0; i < NUM_FAULTS; i++) begin
      victim_flip[i] = '0;
      for (int j = 0; j < NUM_FAULTS; j++) begin
        if (cfin_fire[j] && table_q[j].addr == table_q[i].addr)
          victim_flip[i][table_q[j].bit_idx] = ~victim_flip[i][table_q[j].bit_idx];
      end
    end
  end

  // NOTE: the storage array is deliberately left out of reset; it powers up unknown like real SRAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[eff] <= new_word;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (cfin_fire[i]) mem[table_q[i].addr] <= mem[table_q[i].addr] ^ victim_flip[i];
    end
  end

  // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FAULTS; i++) table_q[i] <= '0;
      s1_data       <= '0;
      s1_hit        <= 1'b0;
      bus.rdata     <= '0;
      bus.fault_hit <= 1'b0;
    end else begin
      if (bus.cfg_we && int'(bus.cfg_idx) < NUM_FAULTS)
        table_q[bus.cfg_idx] <= '{kind: fault_e'(bus.cfg_type), addr: bus.cfg_addr,
                                  aux: bus.cfg_aux_addr, bit_idx: bus.cfg_bit,
                                  data: bus.cfg_data};
      if (!bus.write_read) begin
        s1_data <= rd_word;
        s1_hit  <= rd_hit;
      end else begin
        s1_hit  <= 1'b0;
      end
      bus.rdata     <= s1_data;
      bus.fault_hit <= s1_hit;
    end
  end

`ifdef FAULT_MEM_HIT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       bus.hit_cnt <= '0;
    else if (bus.hit_clr)                             bus.hit_cnt <= '0;
    else if (bus.fault_hit && bus.hit_cnt != 16'hFFFF) bus.hit_cnt <= bus.hit_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fault_mem_multi.sv
// Self-checking bench for fault_mem_multi: directed scenarios then random traffic
// against a behavioural model of the faulty memory.
module tb_fault_mem_multi;
  localparam int DW = 8, AW = 9, CAP = 511, NF = 4, IW = 2, BW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fault_mem_multi_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDX_WIDTH(IW), .BIT_WIDTH(BW)) bus ();

  fault_mem_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP),
                    .NUM_FAULTS(NF), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the memory as a plain array, the table as lists of fields.
  logic [DW-1:0] m_mem [0:CAP];
  int  m_type [NF], m_addr [NF], m_aux [NF], m_bit [NF], m_data [NF];
  logic [DW-1:0] m_last_rd, m_rdata;
  bit  m_pend_hit, m_hit;
  int  m_cnt;
  bit  pend_we, clr_req;
  int  pend_idx, pend_type, pend_addr, pend_aux, pend_bit, pend_data;

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_type[i] = 0;
    m_last_rd = '0; m_rdata = '0; m_pend_hit = 0; m_hit = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit wr, input int a, input int d);
    int e, sidx;
    bit al, sa;
    logic [DW-1:0] old, nw, w;
    e = a; al = 0; sidx = -1; sa = 0;
    for (int i = 0; i < NF; i++)
      if (m_type[i] == 7 && m_addr[i] == a) begin e = m_aux[i]; al = 1; break; end
    for (int i = 0; i < NF; i++)
      if (m_type[i] == 5 && m_addr[i] == e) begin sidx = i; break; end
    if (clr_req) m_cnt = 0;
    else if (m_hit && m_cnt < 16'hFFFF) m_cnt++;
    m_rdata = m_last_rd;
    m_hit   = m_pend_hit;
    if (wr) begin
      m_pend_hit = 0;
      if (sidx < 0) begin
        old = m_mem[e];
        nw  = DW'(d);
        for (int i = 0; i < NF; i++) if (m_addr[i] == e) begin
          if (m_type[i] == 3 && old[m_bit[i]] == 1'b0 && nw[m_bit[i]] == 1'b1) nw[m_bit[i]] = 1'b0;
          if (m_type[i] == 4 && old[m_bit[i]] == 1'b1 && nw[m_bit[i]] == 1'b0) nw[m_bit[i]] = 1'b1;
        end
        for (int i = 0; i < NF; i++) if (m_addr[i] == e) begin
          if (m_type[i] == 1) nw[m_bit[i]] = 1'b0;
          if (m_type[i] == 2) nw[m_bit[i]] = 1'b1;
        end
        for (int i = 0; i < NF; i++)
          if (m_type[i] == 6 && m_aux[i] == e && m_addr[i] != m_aux[i] && ((old ^ nw) >> m_bit[i]) & 1)
            m_mem[m_addr[i]][m_bit[i]] = ~m_mem[m_addr[i]][m_bit[i]];
        m_mem[e] = nw;
      end
    end else begin
      w = (sidx >= 0) ? DW'(m_data[sidx]) : m_mem[e];
      for (int i = 0; i < NF; i++)
        if (m_addr[i] == e && (m_type[i] == 1 || m_type[i] == 2)) begin
          w[m_bit[i]] = (m_type[i] == 2);
          sa = 1;
        end
      m_last_rd  = w;
      m_pend_hit = al || (sidx >= 0) || sa;
    end
    if (pend_we) begin
      m_type[pend_idx] = pend_type; m_addr[pend_idx] = pend_addr; m_aux[pend_idx] = pend_aux;
      m_bit[pend_idx]  = pend_bit;  m_data[pend_idx] = pend_data;
      pend_we = 0;
    end
  endtask

  task automatic compare_outputs();
    if (!$isunknown(m_rdata)) check("rdata", 32'(bus.rdata), 32'(m_rdata));
    check("fault_hit", 32'(bus.fault_hit), 32'(m_hit));
`ifdef FAULT_MEM_HIT_CNT_EN
    check("hit_cnt", 32'(bus.hit_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic set_cfg(input int idx, input int typ, input int a, input int aux,
                         input int b, input int d);
    bus.cfg_we = 1'b1; bus.cfg_idx = IW'(idx); bus.cfg_type = 3'(typ);
    bus.cfg_addr = AW'(a); bus.cfg_aux_addr = AW'(aux); bus.cfg_bit = BW'(b); bus.cfg_data = DW'(d);
    pend_we = 1; pend_idx = idx; pend_type = typ; pend_addr = a; pend_aux = aux;
    pend_bit = b; pend_data = d;
  endtask

  // One access per clock: drive at negedge, model at posedge, compare at the next negedge.
  task automatic cycle(input bit wr, input int a, input int d);
    bus.write_read = wr; bus.address = AW'(a); bus.wdata = DW'(d);
`ifdef FAULT_MEM_HIT_CNT_EN
    bus.hit_clr = clr_req;
`endif
    @(posedge clk);
    model_edge(wr, a, d);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    clr_req = 0;
    compare_outputs();
  endtask

  initial begin
    for (int i = 0; i <= CAP; i++) m_mem[i] = 'x;
    model_reset();
    pend_we = 0; clr_req = 0;
    bus.write_read = 1'b0; bus.address = '0; bus.wdata = '0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_type = '0; bus.cfg_addr = '0;
    bus.cfg_aux_addr = '0; bus.cfg_bit = '0; bus.cfg_data = '0;
`ifdef FAULT_MEM_HIT_CNT_EN
    bus.hit_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_rdata", 32'(bus.rdata), 32'h0);
    check("reset_hit", 32'(bus.fault_hit), 32'h0);
    rst_n = 1'b1;

    // Empty table: plain write then read.
    cycle(1, 3, 'hA5); cycle(0, 3, 0); cycle(0, 3, 0);
    check("plain_rdata", 32'(bus.rdata), 32'hA5);
    check("plain_hit", 32'(bus.fault_hit), 32'h0);

    // STUCK_ADDR at 10.
    set_cfg(0, 5, 10, 0, 0, 'h3C); cycle(0, 3, 0);
    cycle(1, 10, 'hFF); cycle(1, 11, 'h5A); cycle(0, 10, 0); cycle(0, 11, 0);
    check("stuck_rdata", 32'(bus.rdata), 32'h3C);
    check("stuck_hit", 32'(bus.fault_hit), 32'h1);
    cycle(0, 3, 0);
    check("neighbour_rdata", 32'(bus.rdata), 32'h5A);
    check("neighbour_hit", 32'(bus.fault_hit), 32'h0);

    // SA1 bit 0 plus TF_DN bit 7 at 20.
    set_cfg(1, 2, 20, 0, 0, 0); cycle(0, 3, 0);
    set_cfg(2, 4, 20, 0, 7, 0); cycle(0, 3, 0);
    cycle(1, 20, 'h80); cycle(1, 20, 'h00); cycle(0, 20, 0); cycle(0, 3, 0);
    check("sa1_tfdn_rdata", 32'(bus.rdata), 32'h81);
    check("sa1_tfdn_hit", 32'(bus.fault_hit), 32'h1);

    // CFIN victim 5, aggressor 6, bit 2.
    set_cfg(0, 6, 5, 6, 2, 0); cycle(0, 3, 0);
    cycle(1, 5, 'h00); cycle(1, 6, 'h00); cycle(1, 6, 'h04); cycle(0, 5, 0); cycle(0, 3, 0);
    check("cfin_toggle", 32'(bus.rdata), 32'h04);
    cycle(1, 6, 'h04); cycle(0, 5, 0); cycle(0, 3, 0);
    check("cfin_no_toggle", 32'(bus.rdata), 32'h04);

    // ALIAS 30 -> 31 programmed alongside a write to 30.
    set_cfg(3, 7, 30, 31, 0, 0); cycle(1, 30, 'h11);
    cycle(1, 30, 'h22); cycle(0, 31, 0); cycle(0, 30, 0);
    check("alias_dest", 32'(bus.rdata), 32'h22);
    cycle(0, 3, 0);
    check("alias_src", 32'(bus.rdata), 32'h22);
    check("alias_hit", 32'(bus.fault_hit), 32'h1);
    set_cfg(3, 0, 0, 0, 0, 0); cycle(0, 3, 0);
    cycle(0, 30, 0); cycle(0, 3, 0);
    check("alias_old_write", 32'(bus.rdata), 32'h11);

    // Async reset between a read edge and its output.
    set_cfg(3, 5, 3, 0, 0, 'h96); cycle(0, 0, 0);
    cycle(0, 3, 0); cycle(0, 3, 0);
    check("pre_reset_rdata", 32'(bus.rdata), 32'h96);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset_rdata", 32'(bus.rdata), 32'h0);
    check("midreset_hit", 32'(bus.fault_hit), 32'h0);
`ifdef FAULT_MEM_HIT_CNT_EN
    check("midreset_cnt", 32'(bus.hit_cnt), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 3, 0); cycle(0, 3, 0);
    check("table_cleared", 32'(bus.rdata), 32'hA5);
    check("table_cleared_hit", 32'(bus.fault_hit), 32'h0);

    // Random traffic over a small pre-initialised window.
    for (int a = 0; a < 16; a++) cycle(1, a, $urandom_range(0, 255));
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0)
        set_cfg($urandom_range(0, NF - 1), $urandom_range(0, 7), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, DW - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) clr_req = 1;
      cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fault_mem_multi.md
Name: fault_mem_multi

Overview:
- Behavioural faulty-SRAM model used as the device-under-test target for MBIST controller simulation. It generalises the single stuck-address memory.
- Holds a runtime-programmable table of NUM_FAULTS fault entries. Each entry injects one classic memory fault (stuck-at, transition, stuck address, coupling inversion, address alias), so one netlist covers all March-algorithm coverage runs without regenerating RTL.
- Read latency is 2 cycles.
- Write and read share one port.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 9: address width in bits.
- CAPACITY, 511: highest valid word index; the array holds CAPACITY+1 words.
- NUM_FAULTS, 4: number of fault-table entries, 1..16.
- IDX_WIDTH, 2: width of cfg_idx; must satisfy 2**IDX_WIDTH >= NUM_FAULTS.

Ports:
- clk, input, 1: single clock; all logic is posedge.
- rst_n, input, 1: asynchronous active-low reset.
- write_read, input, 1: 1 = write, 0 = read; an access occurs every cycle.
- address, input, ADDR_WIDTH: access address.
- wdata, input, DATA_WIDTH: write data.
- rdata, output, DATA_WIDTH: read data, 2-cycle latency.
- cfg_we, input, 1: fault-table write strobe.
- cfg_idx, input, IDX_WIDTH: table entry selected for writing.
- cfg_type, input, 3: fault type for the entry (encoding in Behaviour).
- cfg_addr, input, ADDR_WIDTH: victim/target address.
- cfg_aux_addr, input, ADDR_WIDTH: aggressor address (CFIN) or alias destination (ALIAS).
- cfg_bit, input, clog2(DATA_WIDTH): faulty bit index.
- cfg_data, input, DATA_WIDTH: fixed read value (STUCK_ADDR).
- fault_hit, output, 1: pulses with rdata when the delivered word was affected by any entry.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata = 0, fault_hit = 0, internal read stage = 0.
  - All table entries cleared to NONE.
  - Array contents are not reset; they stay X until written.
- Fault types:
  - 0 NONE: entry inactive.
  - 1 SA0: bit cfg_bit of cfg_addr always stores and reads 0.
  - 2 SA1: the same as SA0 but the bit is 1.
  - 3 TF_UP: a write cannot change that bit from 0 to 1.
  - 4 TF_DN: a write cannot change that bit from 1 to 0.
  - 5 STUCK_ADDR: writes to cfg_addr are dropped; reads return cfg_data.
  - 6 CFIN: a write to cfg_aux_addr that toggles its bit cfg_bit inverts bit cfg_bit of cfg_addr in the same cycle.
  - 7 ALIAS: accesses to cfg_addr are redirected to cfg_aux_addr.
- Effective address:
  - The lowest-index matching ALIAS entry decides; aliasing is not chained.
  - All other fault matching uses the effective address.
- Write (write_read = 1 at edge T):
  - If a STUCK_ADDR entry matches, the write is dropped.
  - Otherwise new = wdata, with TF masks applied against the old stored word, then SA forces, processed in ascending index order.
  - CFIN: the victim update happens in the same edge.
  - A CFIN entry with cfg_addr == cfg_aux_addr is ignored.
  - If the aggressor write is itself dropped by STUCK_ADDR, no CFIN fires.
- Read (write_read = 0 at edge T):
  - Stage 1 at edge T: word = STUCK_ADDR cfg_data if matched, else mem[eff], then SA forces applied.
  - Stage 2: rdata and fault_hit update at edge T+1, visible after T+1, i.e. 2-cycle latency.
  - During a write cycle, stage 1 holds its value and fault_hit is cleared in the next stage.
- Address range: an address > CAPACITY is a no-op on write and reads 0.
- Configuration timing:
  - cfg_we at edge T updates the entry; the change affects accesses from edge T+1.
  - An access at edge T sees the old table.
- Reset mid-operation: an in-flight read is discarded and rdata = 0.
- A write following a read: no forwarding hazard exists, because stage 1 sampled at the read edge.

Optional Feature:
- Macro: FAULT_MEM_HIT_CNT_EN.
- When defined:
  - Adds output hit_cnt [15:0], reset to 0.
  - hit_cnt increments, saturating at 16'hFFFF, on every cycle fault_hit is 1.
  - Adds input hit_clr; when it is 1, hit_cnt is synchronously cleared, and clear has priority over increment.
- When undefined: neither port exists and the behaviour is otherwise identical.

Test Plan:
- Reset, empty table:
  - Write 8'hA5 to addr 3, then read addr 3 → rdata = 8'hA5 two cycles after the read edge, fault_hit = 0.
- STUCK_ADDR:
  - Entry 0 = {5, addr 10, data 8'h3C}; write 8'hFF to 10, read 10 → rdata = 8'h3C, fault_hit = 1.
  - Reading addr 11 is unaffected.
- SA1 plus TF_DN:
  - Entry 1 = SA1 bit 0 at addr 20, entry 2 = TF_DN bit 7 at addr 20.
  - Write 8'h80, then 8'h00 → read returns 8'h81.
- CFIN:
  - Entry 0 = {6, victim 5, aggressor 6, bit 2}; write 8'h00 to 5 and 8'h00 to 6, then write 8'h04 to 6 → read 5 returns 8'h04.
  - Writing 8'h04 to 6 again (no toggle) → addr 5 unchanged.
- ALIAS plus config timing:
  - Program ALIAS 30 → 31 in the same cycle as a write of 8'h11 to 30 → the write lands at 30.
  - Next, write 8'h22 to 30 → read 31 returns 8'h22, read 30 returns 8'h22.
- Async reset mid-read:
  - Assert rst_n low between the read edge and output → rdata = 0 immediately, table cleared.
  - With FAULT_MEM_HIT_CNT_EN defined, hit_cnt = 0.
